// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end. Holds the PC, addresses a
//               zero-latency instruction memory by word index and captures
//               the returned word into the IF/ID pipeline register.
//               Supports decode stall, redirect with IF/ID flush, and a
//               HALT state entered when the PC leaves the memory range.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               stall               - hold PC, IF/ID and fetch_count
//               redirect_valid/pc   - load aligned target PC, flush IF/ID
//               imem_addr/instr     - word index out, instruction word in
//               id_valid/pc/pc_plus4/instr - IF/ID register contents
//               halted              - fetch stopped on out-of-range PC
//               fetch_count         - instructions delivered since reset
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int          N        = 32,
    parameter int          M        = 256,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    output logic         id_valid,
    output logic [N-1:0] id_pc,
    output logic [N-1:0] id_pc_plus4,
    output logic [N-1:0] id_instr,
    output logic         halted,
    output logic [N-1:0] fetch_count
);

    localparam logic [N-1:0] C_NOP   = N'(32'h0000_0013);
    localparam logic [N-1:0] C_DEPTH = N'(M);
    localparam logic [N-1:0] C_FOUR  = N'(4);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic         r_id_valid;
    logic [N-1:0] r_id_pc;
    logic [N-1:0] r_id_pc_plus4;
    logic [N-1:0] r_id_instr;
    logic         r_halted;
    logic [N-1:0] r_fetch_count;

    state_t       w_state_nxt;
    logic [N-1:0] w_pc_nxt;
    logic         w_id_valid_nxt;
    logic [N-1:0] w_id_pc_nxt;
    logic [N-1:0] w_id_pc_plus4_nxt;
    logic [N-1:0] w_id_instr_nxt;
    logic [N-1:0] w_fetch_count_nxt;
    logic [N-1:0] w_word_idx;
    logic [N-1:0] w_redirect_aligned;
    logic [N-1:0] w_pc_plus4;
    logic         w_in_range;

    assign w_word_idx         = {2'b00, r_pc[N-1:2]};
    assign w_redirect_aligned = {redirect_pc[N-1:2], 2'b00};
    assign w_pc_plus4         = r_pc + C_FOUR;
    assign w_in_range         = (w_word_idx < C_DEPTH);

    // Next-state and next-register values; every target defaults to hold.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_id_instr_nxt    = r_id_instr;
        w_fetch_count_nxt = r_fetch_count;

        case (r_state)
            S_RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall; id_pc/id_pc_plus4 keep their
                    // last values, only the valid flag and word are flushed.
                    w_pc_nxt       = w_redirect_aligned;
                    w_id_valid_nxt = 1'b0;
                    w_id_instr_nxt = C_NOP;
                end else if (stall) begin
                    // hold everything
                end else if (!w_in_range) begin
                    w_state_nxt    = S_HALT;
                    w_id_valid_nxt = 1'b0;
                    w_id_instr_nxt = C_NOP;
                end else begin
                    w_id_valid_nxt    = 1'b1;
                    w_id_pc_nxt       = r_pc;
                    w_id_pc_plus4_nxt = w_pc_plus4;
                    w_id_instr_nxt    = imem_instr;
                    w_pc_nxt          = w_pc_plus4;
                    w_fetch_count_nxt = r_fetch_count + 1'b1;
                end
            end
            S_HALT: begin
                // IF/ID is already flushed on HALT entry; only a redirect
                // restarts fetch. An out-of-range target re-halts next cycle.
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_aligned;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_instr    <= C_NOP;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_halted      <= (w_state_nxt == S_HALT);
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign imem_addr   = w_word_idx;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_instr    = r_id_instr;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Each scenario task
//               drives stimulus and checks inline; delivered instructions
//               are matched against a queue of expected (pc, word) pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int N = 32;
    localparam int M = 256;
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_instr;
    logic         id_valid;
    logic [N-1:0] id_pc;
    logic [N-1:0] id_pc_plus4;
    logic [N-1:0] id_instr;
    logic         halted;
    logic [N-1:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] prev_fc = 32'd0;

    always #5 clk = ~clk;

    // Memory model: word k holds a tagged copy of k.
    function automatic logic [31:0] mem(input logic [31:0] idx);
        return {16'hC0DE, idx[15:0]};
    endfunction

    assign imem_instr = mem(imem_addr);

    fetch_stage #(.N(N), .M(M), .RESET_PC(32'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Each delivery (fetch_count step) pops one expected entry.
    always @(negedge clk) begin
        if (fetch_count !== prev_fc) begin
            if (fetch_count !== 32'd0) begin
                n_vec++;
                if (fetch_count !== prev_fc + 32'd1) begin
                    $display("FAIL sb_count_step got %h exp %h", fetch_count, prev_fc + 32'd1);
                    n_err++;
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_delivery got pc %h exp none", id_pc);
                    n_err++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (id_valid !== 1'b1 || id_pc !== e.pc || id_instr !== e.instr
                        || id_pc_plus4 !== e.pc + 32'd4) begin
                        $display("FAIL sb_delivery got v=%b pc=%h instr=%h pc4=%h exp v=1 pc=%h instr=%h pc4=%h",
                                 id_valid, id_pc, id_instr, id_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
                        n_err++;
                    end
                end
            end
            prev_fc = fetch_count;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem(pc >> 2);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (imem_addr !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0
            || id_instr !== C_NOP || halted !== 1'b0 || fetch_count !== 32'd0) begin
            $display("FAIL reset_state got addr=%h v=%b pc=%h pc4=%h instr=%h h=%b fc=%h exp 0/0/0/0/13/0/0",
                     imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, halted, fetch_count);
            n_err++;
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            push_exp(32'(4 * k));
            tick();
            n_vec++;
            if (imem_addr !== 32'(k + 1) || id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
                $display("FAIL seq_step%0d got addr=%h v=%b pc=%h exp addr=%h v=1 pc=%h",
                         k, imem_addr, id_valid, id_pc, k + 1, 4 * k);
                n_err++;
            end
        end
        n_vec++;
        if (fetch_count !== 32'd4) begin
            $display("FAIL seq_count got %h exp 4", fetch_count);
            n_err++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        push_exp(32'd0); tick();
        push_exp(32'd4); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (imem_addr !== 32'd2 || id_pc !== 32'd4 || id_valid !== 1'b1 || fetch_count !== 32'd2) begin
                $display("FAIL stall_hold%0d got addr=%h pc=%h v=%b fc=%h exp 2/4/1/2",
                         i, imem_addr, id_pc, id_valid, fetch_count);
                n_err++;
            end
        end
        stall = 1'b0;
        push_exp(32'd8);
        tick();
        n_vec++;
        if (id_pc !== 32'd8 || fetch_count !== 32'd3 || imem_addr !== 32'd3) begin
            $display("FAIL stall_release got pc=%h fc=%h addr=%h exp 8/3/3", id_pc, fetch_count, imem_addr);
            n_err++;
        end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1; redirect_pc = 32'h16; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        n_vec++;
        if (imem_addr !== 32'd5 || id_valid !== 1'b0 || id_instr !== C_NOP || id_pc !== 32'd8
            || fetch_count !== 32'd3) begin
            $display("FAIL redir_flush got addr=%h v=%b instr=%h pc=%h fc=%h exp 5/0/13/8/3",
                     imem_addr, id_valid, id_instr, id_pc, fetch_count);
            n_err++;
        end
        push_exp(32'h14);
        tick();
        n_vec++;
        if (id_pc !== 32'h14 || id_valid !== 1'b1 || fetch_count !== 32'd4) begin
            $display("FAIL redir_deliver got pc=%h v=%b fc=%h exp 14/1/4", id_pc, id_valid, fetch_count);
            n_err++;
        end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        push_exp(32'h3FC);
        tick();
        n_vec++;
        if (id_pc !== 32'h3FC || id_valid !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'd256) begin
            $display("FAIL halt_last got pc=%h v=%b h=%b addr=%h exp 3fc/1/0/100",
                     id_pc, id_valid, halted, imem_addr);
            n_err++;
        end
        tick();
        n_vec++;
        if (halted !== 1'b1 || id_valid !== 1'b0 || id_instr !== C_NOP || imem_addr !== 32'd256
            || fetch_count !== 32'd5) begin
            $display("FAIL halt_enter got h=%b v=%b instr=%h addr=%h fc=%h exp 1/0/13/100/5",
                     halted, id_valid, id_instr, imem_addr, fetch_count);
            n_err++;
        end
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            tick();
            n_vec++;
            if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'd256 || fetch_count !== 32'd5) begin
                $display("FAIL halt_frozen%0d got h=%b v=%b addr=%h fc=%h exp 1/0/100/5",
                         i, halted, id_valid, imem_addr, fetch_count);
                n_err++;
            end
        end
        stall = 1'b0;
        // Redirecting to another out-of-range target re-halts after one cycle.
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (halted !== 1'b0 || imem_addr !== 32'h140) begin
            $display("FAIL halt_oor_redir got h=%b addr=%h exp 0/140", halted, imem_addr);
            n_err++;
        end
        tick();
        n_vec++;
        if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h140) begin
            $display("FAIL halt_reenter got h=%b v=%b addr=%h exp 1/0/140", halted, id_valid, imem_addr);
            n_err++;
        end
    endtask

    task automatic test_halt_recovery();
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (halted !== 1'b0 || imem_addr !== 32'd2 || id_valid !== 1'b0) begin
            $display("FAIL recover_redir got h=%b addr=%h v=%b exp 0/2/0", halted, imem_addr, id_valid);
            n_err++;
        end
        push_exp(32'h8);
        tick();
        n_vec++;
        if (id_pc !== 32'd8 || id_valid !== 1'b1 || fetch_count !== 32'd6) begin
            $display("FAIL recover_deliver got pc=%h v=%b fc=%h exp 8/1/6", id_pc, id_valid, fetch_count);
            n_err++;
        end
    endtask

    task automatic test_reset_midop();
        stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        n_vec++;
        if (imem_addr !== 32'd0 || id_valid !== 1'b0 || id_instr !== C_NOP || fetch_count !== 32'd0
            || halted !== 1'b0 || id_pc !== 32'd0) begin
            $display("FAIL reset_midop got addr=%h v=%b instr=%h fc=%h h=%b pc=%h exp 0/0/13/0/0/0",
                     imem_addr, id_valid, id_instr, fetch_count, halted, id_pc);
            n_err++;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_halt_recovery();
        test_reset_midop();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
